// File: rtl/serdes_tx_sched.sv
// serdes_tx_sched: two-requester round-robin transmit scheduler feeding an
// MSB-first parallel-to-serial shifter. Slots are WIDTH cycles long. Slots
// with no granted byte carry IDLE_BYTE, so the serial line never stalls.
module serdes_tx_sched #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_BYTE = 8'hBC,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             slot_start,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int              BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

  logic [BCW-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic             valid_q,     valid_d;
  logic             last_gnt_q,  last_gnt_d;   // 1 = requester 1 was granted last
  logic [CNT_W-1:0] sent_cnt_q,  sent_cnt_d;
  logic             gnt0_q,      gnt0_d;
  logic             gnt1_q,      gnt1_d;

  logic             pick0;
  logic             pick1;

  // Round-robin choice; only consulted on the slot-boundary cycle.
  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick0 = req0 && (!req1 || last_gnt_q);
    pick1 = req1 && (!req0 || !last_gnt_q);
  end

  // Next-state: shift within a slot, arbitrate and reload on the last bit.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    valid_d    = valid_q;
    last_gnt_d = last_gnt_q;
    sent_cnt_d = sent_cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    if (enb) begin
      if (bit_cnt_q != LAST_BIT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        bit_cnt_d = '0;
        if (pick0 || pick1) begin
          shreg_d    = pick0 ? data0 : data1;
          gnt0_d     = pick0;
          gnt1_d     = pick1;
          valid_d    = 1'b1;
          last_gnt_d = pick1;
          if (!(&sent_cnt_q)) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
          end
        end else begin
          shreg_d = IDLE_BYTE;
          valid_d = 1'b0;
        end
      end
    end
  end

  // State registers; reset aborts any byte in flight and restarts an idle slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shreg_q    <= IDLE_BYTE;
      valid_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      sent_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      valid_q    <= valid_d;
      last_gnt_q <= last_gnt_d;
      sent_cnt_q <= sent_cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
    end
  end

  // Output mapping; slot_start is decoded straight from the bit counter.
  always_comb begin
    ser_out    = shreg_q[WIDTH-1];
    ser_valid  = valid_q;
    slot_start = (bit_cnt_q == '0);
    gnt0       = gnt0_q;
    gnt1       = gnt1_q;
    sent_cnt   = sent_cnt_q;
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// tb_serdes_tx_sched: scoreboard bench. Each stimulus slot pushes the slot
// the scheduler should send next; a negedge monitor pops it at the slot's
// first bit and rebuilds the serial byte. A 4-bit sent counter keeps the
// saturation case reachable in a short run.
module tb_serdes_tx_sched;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enb = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic             gnt0, gnt1, ser_out, ser_valid, slot_start;
  logic [CNT_W-1:0] sent_cnt;

  serdes_tx_sched #(.WIDTH(WIDTH), .IDLE_BYTE(IDLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .ser_out(ser_out), .ser_valid(ser_valid),
    .slot_start(slot_start), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             g0;
    logic             g1;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   mon_en = 1'b0;

  // reference arbiter state
  logic             m_last = 1'b1;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1);
    exp_t e;
    e.g0 = 1'b0; e.g1 = 1'b0; e.valid = 1'b0; e.data = IDLE;
    if (r0 && (!r1 || m_last)) begin
      e.g0 = 1'b1; e.valid = 1'b1; e.data = d0; m_last = 1'b0;
    end else if (r1) begin
      e.g1 = 1'b1; e.valid = 1'b1; e.data = d1; m_last = 1'b1;
    end
    if (e.valid && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    $display("[TB] slot queued: data=%02h valid=%0b gnt0=%0b gnt1=%0b cnt=%0d", e.data, e.valid, e.g0, e.g1, e.cnt);
  endtask

  // Hold requests for the slot in progress; they decide the following slot.
  task automatic drive_slot(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                            input int stall_at);
    req0 = r0; data0 = d0; req1 = r1; data1 = d1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == stall_at) begin
        enb = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        enb = 1'b1;
      end
      @(posedge clk); #1;
    end
    push_exp(r0, d0, r1, d1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    m_last = 1'b1;
    m_cnt  = '0;
    push_exp(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Monitor: one line per completed slot, checks every observed bit cycle.
  int               bit_idx = 0;
  logic [WIDTH-1:0] captured = '0;
  exp_t             cur;

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      bit_idx = 0;
    end else begin
      check("slot_start", {31'd0, slot_start}, {31'd0, (bit_idx == 0)});
      if (bit_idx != 0) begin
        check("gnt_mid", {30'd0, gnt1, gnt0}, 32'd0);
      end
      if (enb) begin
        if (bit_idx == 0) begin
          if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 32'd1);
            cur.data = IDLE; cur.valid = 1'b0; cur.g0 = 1'b0; cur.g1 = 1'b0; cur.cnt = sent_cnt;
          end else begin
            cur = sb_q.pop_front();
          end
          check("gnt0", {31'd0, gnt0}, {31'd0, cur.g0});
          check("gnt1", {31'd0, gnt1}, {31'd0, cur.g1});
          check("sent_cnt", {28'd0, sent_cnt}, {28'd0, cur.cnt});
        end
        check("ser_valid", {31'd0, ser_valid}, {31'd0, cur.valid});
        captured[WIDTH-1-bit_idx] = ser_out;
        bit_idx++;
        if (bit_idx == WIDTH) begin
          check("ser_byte", {24'd0, captured}, {24'd0, cur.data});
          $display("[TB] slot done: byte=%02h valid=%0b cnt=%0d", captured, cur.valid, sent_cnt);
          bit_idx = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ser_out", {31'd0, ser_out}, 32'd1);
    check("rst_valid", {31'd0, ser_valid}, 32'd0);
    check("rst_slot_start", {31'd0, slot_start}, 32'd1);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_cnt", {28'd0, sent_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    push_exp(1'b0, 8'h00, 1'b0, 8'h00);

    // idle slots
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);

    // single requester 0
    drive_slot(1'b1, 8'h88, 1'b0, 8'h00, -1);
    drive_slot(1'b0, 8'h88, 1'b0, 8'h00, -1);

    // round-robin from a fresh reset: req0 wins the first tie
    do_reset();
    drive_slot(1'b1, 8'hA5, 1'b1, 8'h3C, -1);
    drive_slot(1'b0, 8'hA5, 1'b1, 8'h3C, -1);
    drive_slot(1'b1, 8'hA5, 1'b0, 8'h3C, -1);
    drive_slot(1'b1, 8'hA5, 1'b1, 8'h3C, -1);
    drive_slot(1'b1, 8'hA5, 1'b1, 8'h3C, -1);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);

    // enable stall mid-slot while F0 is on the line
    drive_slot(1'b1, 8'hF0, 1'b0, 8'h00, -1);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, 3);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);

    // reset at bit 4 of C3 with req1 pending
    drive_slot(1'b1, 8'hC3, 1'b0, 8'h00, -1);
    req0 = 1'b0; req1 = 1'b1; data1 = 8'h5A;
    repeat (4) begin @(posedge clk); #1; end
    do_reset();
    drive_slot(1'b0, 8'h00, 1'b1, 8'h5A, -1);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);

    // counter saturation (all-ones = 15 with the narrow counter)
    for (int i = 0; i < 16; i++) begin
      drive_slot(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, -1);
    end
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);
    drive_slot(1'b0, 8'h00, 1'b0, 8'h00, -1);
    check("sat_cnt", {28'd0, sent_cnt}, {28'd0, m_cnt});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
